// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU controller.
//   S_IDLE..S_DONE : 2-bit state encodings
//   DIV_ITERS      : restoring iterations per divide (one per operand bit)
//   DIV_LATENCY    : cycles from the accepted start to the div_done pulse
//   div_state_e    : FSM state type built on the encodings above
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int DIV_ITERS   = 32;
  localparam int DIV_LATENCY = 34;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    ITER = S_ITER,
    FIX  = S_FIX,
    DONE = S_DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step, purely combinational.
//   r_i : partial remainder (WIDTH+1 bits)
//   q_i : quotient / dividend shift register
//   d_i : divisor magnitude
//   r_o : next partial remainder
//   q_o : next quotient shift register
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH:0]   t;
  logic             sub_ok;

  assign r_sh = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
  assign q_sh = {q_i[WIDTH-2:0], 1'b0};
  assign t    = r_sh - {1'b0, d_i};

  // A set r_i MSB would shift out as weight 2^(WIDTH+1), which always exceeds
  // the divisor, so the subtraction then succeeds regardless of the borrow.
  assign sub_ok = r_i[WIDTH] | ~t[WIDTH];

  assign r_o = sub_ok ? t : r_sh;
  assign q_o = {q_sh[WIDTH-1:1], sub_ok};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller: 32 restoring iterations, sign fix, HI/LO write.
//   clk, resetn            : clock, async active-low reset
//   div_start, div_signed  : issue strobe and DIV(1)/DIVU(0) select, sampled in IDLE
//   dividend, divisor      : rs / rt operands, sampled with div_start
//   cancel                 : exception/interrupt abort, wins over div_start
//   div_busy               : stall request towards the hazard logic
//   div_done, hilo_we      : one-cycle result strobe
//   quotient, remainder    : LO / HI values, held until the next completed divide
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             div_busy,
  output logic             div_done,
  output logic             hilo_we,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             sq_q;
  logic             sr_q;
  logic             done_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;

  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] quo_d;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;

  // Magnitudes are plain unsigned values, so -(0x80000000) stays 0x80000000.
  assign neg_a = div_signed & dividend[WIDTH-1];
  assign neg_b = div_signed & divisor[WIDTH-1];
  assign abs_a = neg_a ? -dividend : dividend;
  assign abs_b = neg_b ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_i (rem_q),
    .q_i (quo_q),
    .d_i (dvs_q),
    .r_o (rem_d),
    .q_o (quo_d)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      sq_q        <= 1'b0;
      sr_q        <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cancel) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (div_start) begin
              sq_q    <= neg_a ^ neg_b;
              sr_q    <= neg_a;
              quo_q   <= abs_a;
              dvs_q   <= abs_b;
              rem_q   <= '0;
              cnt_q   <= '0;
              state_q <= ITER;
            end
          end
          ITER: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_q <= FIX;
          end
          FIX: begin
            quotient_q  <= sq_q ? -quo_q : quo_q;
            remainder_q <= sr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            done_q      <= 1'b1;
            state_q     <= DONE;
          end
          DONE: state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign div_busy  = (state_q == ITER) | (state_q == FIX) |
                     ((state_q == IDLE) & div_start & ~cancel);
  assign div_done  = done_q;
  assign hilo_we   = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: tb/tb_div_sequencer.sv
module tb_div_sequencer;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
  } res_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        div_busy;
  logic        div_done;
  logic        hilo_we;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int   checks = 0;
  int   failures = 0;
  res_t sb[$];
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  div_sequencer #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .div_start  (div_start),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .div_busy   (div_busy),
    .div_done   (div_done),
    .hilo_we    (hilo_we),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    res_t e;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (sg) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Issues one divide in cycle T and follows it to completion. When no_wait is
  // set, the caller is already inside cycle T.
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input res_t exp, input int pulse_at,
                         input bit no_wait);
    res_t e;
    bit   got;
    if (!no_wait) begin
      @(posedge clk); #1;
    end
    div_start  = 1'b1;
    div_signed = sg;
    dividend   = a;
    divisor    = b;
    cancel     = 1'b0;
    sb.push_back(exp);
    #4;
    check({tag, "/busy_T"}, 32'(div_busy), 32'd1);
    got = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clk); #1;
      div_start  = (i == pulse_at);
      div_signed = ~sg;
      dividend   = 32'h0000_03E8;
      divisor    = 32'h0000_000A;
      #4;
      if (i == 1) check({tag, "/busy_T1"}, 32'(div_busy), 32'd1);
      if (i == pulse_at) check({tag, "/busy_pulse"}, 32'(div_busy), 32'd1);
      if (i == 33) begin
        check({tag, "/busy_T33"}, 32'(div_busy), 32'd1);
        check({tag, "/done_T33"}, 32'(div_done), 32'd0);
      end
      if (div_done) begin
        got = 1'b1;
        check({tag, "/latency"}, 32'(i), 32'd34);
        check({tag, "/busy_done"}, 32'(div_busy), 32'd0);
        check({tag, "/hilo_we"}, 32'(hilo_we), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check({tag, "/q"}, quotient, e.q);
          check({tag, "/r"}, remainder, e.r);
          last_q = e.q;
          last_r = e.r;
        end
      end
    end
    check({tag, "/completed"}, 32'(got), 32'd1);
    div_start = 1'b0;
    @(posedge clk); #5;
    check({tag, "/done_T35"}, 32'(div_done), 32'd0);
    check({tag, "/busy_T35"}, 32'(div_busy), 32'd0);
  endtask

  initial begin
    res_t  e;
    logic  sg;
    logic [31:0] a;
    logic [31:0] b;

    // reset state
    @(posedge clk); #5;
    check("rst/q", quotient, 32'd0);
    check("rst/r", remainder, 32'd0);
    check("rst/done", 32'(div_done), 32'd0);
    check("rst/hilo_we", 32'(hilo_we), 32'd0);
    check("rst/busy", 32'(div_busy), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    e.q = 32'd14;         e.r = 32'd2;
    run_div("u100_7", 1'b0, 32'd100, 32'd7, e, -1, 1'b0);
    e.q = 32'hFFFF_FFFD;  e.r = 32'hFFFF_FFFF;
    run_div("sm7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, e, -1, 1'b0);
    e.q = 32'hFFFF_FFFD;  e.r = 32'd1;
    run_div("s7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, e, -1, 1'b0);
    e.q = 32'h8000_0000;  e.r = 32'd0;
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, e, -1, 1'b0);
    e.q = 32'hFFFF_FFFF;  e.r = 32'h1234_5678;
    run_div("u_div0", 1'b0, 32'h1234_5678, 32'd0, e, -1, 1'b0);
    e.q = 32'h0FFF_FFFF;  e.r = 32'hF;
    run_div("u_ign_start", 1'b0, 32'hFFFF_FFFF, 32'h10, e, 3, 1'b0);
    e.q = 32'd14;         e.r = 32'hFFFF_FFFE;
    run_div("sm100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, e, -1, 1'b0);

    // cancel at T+10, restart at T+11
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd50; divisor = 32'd3;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      div_start = 1'b0;
      cancel = (i == 10);
      #4;
      check("cancel/no_done", 32'(div_done), 32'd0);
    end
    @(posedge clk); #1;
    cancel = 1'b0;
    #2;
    check("cancel/busy_C1", 32'(div_busy), 32'd0);
    check("cancel/done_C1", 32'(div_done), 32'd0);
    check("cancel/hilo_C1", 32'(hilo_we), 32'd0);
    check("cancel/q_held", quotient, last_q);
    check("cancel/r_held", remainder, last_r);
    #1;
    e.q = 32'd30; e.r = 32'd10;
    run_div("restart", 1'b0, 32'd1000, 32'd33, e, -1, 1'b1);

    // start and cancel in the same cycle: cancel wins
    @(posedge clk); #1;
    div_start = 1'b1; cancel = 1'b1; dividend = 32'd9; divisor = 32'd3;
    #4;
    check("start_cancel/busy_T", 32'(div_busy), 32'd0);
    @(posedge clk); #1;
    div_start = 1'b0; cancel = 1'b0;
    #4;
    check("start_cancel/busy_T1", 32'(div_busy), 32'd0);
    check("start_cancel/q_held", quotient, last_q);

    // asynchronous reset at T+20
    @(posedge clk); #1;
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      div_start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    check("areset/q", quotient, 32'd0);
    check("areset/r", remainder, 32'd0);
    check("areset/done", 32'(div_done), 32'd0);
    check("areset/hilo_we", 32'(hilo_we), 32'd0);
    check("areset/busy", 32'(div_busy), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    last_q = '0; last_r = '0;
    e.q = 32'd14; e.r = 32'd2;
    run_div("post_reset", 1'b0, 32'd100, 32'd7, e, -1, 1'b0);

    // model-driven operands
    for (int k = 0; k < 4; k++) begin
      sg = k[0];
      a  = $urandom;
      b  = 32'($urandom_range(1, 65535));
      if (sg && $urandom_range(0, 1) == 1) b = -b;
      e  = model(sg, a, b);
      run_div($sformatf("rand%0d", k), sg, a, b, e, -1, 1'b0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
